multiway_data_array: RTL and testbench

//  Parametrised N-way cache data store: per-way, per-byte masked writes and a registered 1-cycle read.

---
 rtl/multiway_data_array.sv | 134 +++++++++++++
 tb/tb_multiway_data_array.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiway_data_array.sv
// rtl/multiway_data_array.sv - N-way cache data store with byte-masked writes, registered read and clear sweep
// Optional per-byte even parity storage and checking is enabled with `define PARITY_EN.
module multiway_data_array #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_way    = 1,
  parameter int s_mask   = 2**s_offset,
  parameter int s_line   = 8*s_mask,
  parameter int num_sets = 2**s_index,
  parameter int num_ways = 2**s_way
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read,
  input  logic [s_index-1:0]  rindex,
  input  logic [s_way-1:0]    rway,
  input  logic [s_mask-1:0]   write_en,
  input  logic [s_index-1:0]  windex,
  input  logic [s_way-1:0]    wway,
  input  logic [s_line-1:0]   datain,
  input  logic                clear,
  input  logic [s_mask-1:0]   par_inject,
  output logic [s_line-1:0]   dataout,
  output logic                rvalid,
  output logic                busy,
  output logic                parity_err
);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t             state, state_next;
  logic [s_index-1:0] ptr, ptr_next;
  logic [s_line-1:0]  mem [num_sets][num_ways];
  logic [s_line-1:0]  merged;
  logic [s_mask-1:0]  fwd;
  logic               accept;
  logic               rd_err;

  assign busy   = (state == CLEAR);
  assign accept = read && !busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      CLEAR: begin
        ptr_next = ptr + 1'b1;
        if (ptr == s_index'(num_sets-1)) begin
          state_next = IDLE;
          ptr_next   = '0;
        end
      end
      IDLE: begin
        if (clear) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // Write-first merge: bytes written this cycle to the line being read are forwarded.
  always_comb begin
    fwd    = '0;
    merged = '0;
    for (int i = 0; i < s_mask; i++) begin
      fwd[i] = write_en[i] && (windex == rindex) && (wway == rway);
      merged[8*i +: 8] = fwd[i] ? datain[8*i +: 8] : mem[rindex][rway][8*i +: 8];
    end
  end

`ifdef PARITY_EN
  logic [s_mask-1:0] pmem [num_sets][num_ways];
  logic [s_mask-1:0] merged_par;
  logic [s_mask-1:0] err_bits;

  always_comb begin
    merged_par = '0;
    err_bits   = '0;
    for (int i = 0; i < s_mask; i++) begin
      merged_par[i] = fwd[i] ? (^datain[8*i +: 8]) ^ par_inject[i] : pmem[rindex][rway][i];
      err_bits[i]   = (^merged[8*i +: 8]) ^ merged_par[i];
    end
  end
  assign rd_err = |err_bits;

  always_ff @(posedge clk) begin
    if (busy) begin
      for (int w = 0; w < num_ways; w++) pmem[ptr][s_way'(w)] <= '0;
    end else begin
      for (int i = 0; i < s_mask; i++)
        if (write_en[i]) pmem[windex][wway][i] <= (^datain[8*i +: 8]) ^ par_inject[i];
    end
  end
`else
  logic unused_par;
  assign unused_par = ^par_inject;
  assign rd_err     = 1'b0;
`endif

  // Storage has no reset; the sweep zeroes one set (all ways) per cycle.
  always_ff @(posedge clk) begin
    if (busy) begin
      for (int w = 0; w < num_ways; w++) mem[ptr][s_way'(w)] <= '0;
    end else begin
      for (int i = 0; i < s_mask; i++)
        if (write_en[i]) mem[windex][wway][8*i +: 8] <= datain[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataout    <= '0;
      rvalid     <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rvalid     <= accept;
      dataout    <= accept ? merged : '0;
      parity_err <= accept && rd_err;
    end
  end

endmodule

// File: tb/tb_multiway_data_array.sv
// tb/tb_multiway_data_array.sv - scoreboard bench for multiway_data_array
module tb_multiway_data_array;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         read = 1'b0;
  logic [2:0]   rindex = '0;
  logic         rway = 1'b0;
  logic [31:0]  write_en = '0;
  logic [2:0]   windex = '0;
  logic         wway = 1'b0;
  logic [255:0] datain = '0;
  logic         clear = 1'b0;
  logic [31:0]  par_inject = '0;
  logic [255:0] dataout;
  logic         rvalid;
  logic         busy;
  logic         parity_err;

  multiway_data_array dut (
    .clk(clk), .rst(rst), .read(read), .rindex(rindex), .rway(rway),
    .write_en(write_en), .windex(windex), .wway(wway), .datain(datain),
    .clear(clear), .par_inject(par_inject), .dataout(dataout),
    .rvalid(rvalid), .busy(busy), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         valid;
    logic [255:0] data;
    logic         perr;
  } exp_t;

  exp_t         sb[$];
  logic [255:0] model     [8][2];
  logic [31:0]  model_inj [8][2];
  int           exp_sweep = 0;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic zero_model();
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 2; w++) begin
        model[s][w]     = '0;
        model_inj[s][w] = '0;
      end
  endtask

  // One clock slot: drive, predict, step, compare the registered response.
  task automatic cycle(input logic rd, input logic [2:0] ri, input logic rw,
                       input logic [31:0] we, input logic [2:0] wi, input logic ww,
                       input logic [255:0] d, input logic [31:0] inj, input logic clr);
    exp_t e;
    exp_t got;
    logic busy_now;
    logic pe;
    read = rd; rindex = ri; rway = rw; write_en = we; windex = wi; wway = ww;
    datain = d; par_inject = inj; clear = clr;
    busy_now = (exp_sweep > 0);
    #1;
    n_cmp++;
    if (busy !== busy_now) begin
      n_err++; $display("FAIL busy: got %b want %b at %0t", busy, busy_now, $time);
    end
    e.valid = rd && !busy_now;
    e.data  = '0;
    e.perr  = 1'b0;
    if (e.valid) begin
      for (int i = 0; i < 32; i++) begin
        if (we[i] && wi == ri && ww == rw) begin
          e.data[8*i +: 8] = d[8*i +: 8];
          pe = inj[i];
        end else begin
          e.data[8*i +: 8] = model[ri][rw][8*i +: 8];
          pe = model_inj[ri][rw][i];
        end
        e.perr = e.perr | pe;
      end
    end
`ifndef PARITY_EN
    e.perr = 1'b0;
`endif
    sb.push_back(e);
    if (!busy_now)
      for (int i = 0; i < 32; i++)
        if (we[i]) begin
          model[wi][ww][8*i +: 8] = d[8*i +: 8];
          model_inj[wi][ww][i]    = inj[i];
        end
    @(posedge clk); #1;
    if (busy_now) exp_sweep--;
    else if (clr) begin
      exp_sweep = 8;
      zero_model();
    end
    got.valid = rvalid; got.data = dataout; got.perr = parity_err;
    e = sb.pop_front();
    n_cmp++;
    if (got.valid !== e.valid) begin
      n_err++; $display("FAIL rvalid: got %b want %b at %0t", got.valid, e.valid, $time);
    end
    n_cmp++;
    if (got.data !== e.data) begin
      n_err++; $display("FAIL dataout: got %h want %h at %0t", got.data, e.data, $time);
    end
    n_cmp++;
    if (got.perr !== e.perr) begin
      n_err++; $display("FAIL parity_err: got %b want %b at %0t", got.perr, e.perr, $time);
    end
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 3'd0, 1'b0, 32'h0, 3'd0, 1'b0, '0, 32'h0, 1'b0);
  endtask

  task automatic rd_cycle(input logic [2:0] ri, input logic rw);
    cycle(1'b1, ri, rw, 32'h0, 3'd0, 1'b0, '0, 32'h0, 1'b0);
  endtask

  task automatic wr_cycle(input logic [31:0] we, input logic [2:0] wi, input logic ww,
                          input logic [255:0] d, input logic [31:0] inj);
    cycle(1'b0, 3'd0, 1'b0, we, wi, ww, d, inj, 1'b0);
  endtask

  task automatic hold_reset(input int n);
    read = 1'b0; write_en = '0; clear = 1'b0; par_inject = '0;
    rst = 1'b1;
    #1;
    for (int k = 0; k < n; k++) begin
      n_cmp++;
      if (dataout !== '0 || rvalid !== 1'b0 || parity_err !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL reset_state: dout=%h rvalid=%b perr=%b busy=%b want 0/0/0/1",
                 dataout, rvalid, parity_err, busy);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    exp_sweep = 8;
    zero_model();
  endtask

  task automatic test_reset();
    hold_reset(3);
    for (int k = 0; k < 8; k++) rd_cycle(3'd5, 1'b0);
    rd_cycle(3'd5, 1'b0);
  endtask

  task automatic test_masked_write();
    wr_cycle(32'hFFFF_FFFF, 3'd2, 1'b1, {32{8'hA5}}, 32'h0);
    wr_cycle(32'h0000_0001, 3'd2, 1'b1, {{31{8'h00}}, 8'h3C}, 32'h0);
    rd_cycle(3'd2, 1'b1);
    rd_cycle(3'd2, 1'b0);
  endtask

  task automatic test_write_first();
    cycle(1'b1, 3'd2, 1'b1, 32'h0000_00F0, 3'd2, 1'b1, {32{8'h11}}, 32'h0, 1'b0);
    rd_cycle(3'd2, 1'b1);
    cycle(1'b1, 3'd2, 1'b1, 32'h0000_0F00, 3'd2, 1'b0, {32{8'h77}}, 32'h0, 1'b0);
    rd_cycle(3'd2, 1'b0);
  endtask

  task automatic test_noop_x();
    cycle(1'b1, 3'd2, 1'b1, 32'h0, 3'bxxx, 1'bx, {256{1'bx}}, 32'h0, 1'b0);
    rd_cycle(3'd2, 1'b1);
  endtask

  task automatic test_clear();
    wr_cycle(32'hFFFF_FFFF, 3'd7, 1'b0, {32{8'h5A}}, 32'h0);
    cycle(1'b0, 3'd0, 1'b0, 32'h0, 3'd0, 1'b0, '0, 32'h0, 1'b1);
    for (int k = 0; k < 8; k++)
      cycle(1'b1, 3'd7, 1'b0, 32'hFFFF_FFFF, 3'd3, 1'b1, {32{8'hEE}}, 32'h0, k == 3);
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 2; w++) rd_cycle(3'(s), w[0]);
  endtask

  task automatic test_reset_mid_sweep();
    cycle(1'b0, 3'd0, 1'b0, 32'h0, 3'd0, 1'b0, '0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) idle_cycle();
    hold_reset(2);
    for (int k = 0; k < 8; k++) rd_cycle(3'd1, 1'b1);
    rd_cycle(3'd1, 1'b1);
  endtask

  task automatic test_parity();
    wr_cycle(32'h0000_0008, 3'd4, 1'b0, {{28{8'h00}}, 8'h01, 24'h0}, 32'h8);
    rd_cycle(3'd4, 1'b0);
    wr_cycle(32'h0000_0008, 3'd4, 1'b0, {{28{8'h00}}, 8'h01, 24'h0}, 32'h0);
    rd_cycle(3'd4, 1'b0);
    cycle(1'b1, 3'd4, 1'b0, 32'h0000_0001, 3'd4, 1'b0, {32{8'h03}}, 32'h1, 1'b0);
    rd_cycle(3'd4, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      logic [31:0]  we;
      logic [255:0] d;
      we = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom;
      cycle($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            we, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), d,
            ($urandom_range(0, 3) == 0) ? $urandom : 32'h0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_write_first();
    test_noop_x();
    test_clear();
    test_reset_mid_sweep();
    test_parity();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
